// File: rtl/instr_fetch_if.sv
// Signal bundle between the instruction fetch unit, the decode stage and instruction memory.
// The master modport is the fetch unit; the slave modport is everything around it.
interface instr_fetch_if;
   logic        en_pc;
   logic        en_IF;
   logic        flush;
   logic        pcSrc;
   logic [31:0] branchPC;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;

   modport master (
      input  en_pc, en_IF, flush, pcSrc, branchPC,
      input  imem_gnt, imem_rvalid, imem_rdata,
      output imem_req, imem_addr,
      output if_pc, if_instr, if_valid
   );

   modport slave (
      output en_pc, en_IF, flush, pcSrc, branchPC,
      output imem_gnt, imem_rvalid, imem_rdata,
      input  imem_req, imem_addr,
      input  if_pc, if_instr, if_valid
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the fetch PC, runs one outstanding req/gnt/rvalid transaction at a time,
// buffers returned words in a small FIFO and feeds the IF/ID register with stall/flush/redirect.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   instr_fetch_if.master bus
);

   localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CW = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

   state_t          state_reg, state_next;
   logic [31:0]     fpc_reg;
   logic [31:0]     req_pc_reg;
   logic [31:0]     buf_pc    [BUF_DEPTH];
   logic [31:0]     buf_instr [BUF_DEPTH];
   logic [PW-1:0]   rd_ptr_reg, wr_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [31:0]     if_pc_reg, if_instr_reg;
   logic            if_valid_reg;

   logic            req, grant, push, pop, empty;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (grant) state_next = WAIT;
         WAIT:    if (bus.imem_rvalid) state_next = IDLE;
                  else if (bus.pcSrc)  state_next = DISCARD;
         DISCARD: if (bus.imem_rvalid) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Requests only launch when the FIFO has a free slot, so a response can always be pushed.
   always_comb begin
      req  = 1'b0;
      push = 1'b0;
      if (!rst && state_reg == IDLE && bus.en_pc && !bus.pcSrc &&
          count_reg < CW'(BUF_DEPTH))
         req = 1'b1;
      if (state_reg == WAIT && bus.imem_rvalid && !bus.pcSrc)
         push = 1'b1;
   end

   assign grant         = req & bus.imem_gnt;
   assign bus.imem_req  = req;
   assign bus.imem_addr = fpc_reg;
   assign empty         = (count_reg == '0);
   assign pop           = !bus.pcSrc && (bus.flush || bus.en_IF) && !empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fpc_reg    <= RESET_PC;
         req_pc_reg <= '0;
      end else if (bus.pcSrc) begin
         fpc_reg    <= bus.branchPC;
      end else if (grant) begin
         req_pc_reg <= fpc_reg;
         fpc_reg    <= fpc_reg + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (bus.pcSrc) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Entry storage needs no reset: count_reg decides which slots are meaningful.
   generate
      for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push && wr_ptr_reg == PW'(gi)) begin
               buf_pc[gi]    <= req_pc_reg;
               buf_instr[gi] <= bus.imem_rdata;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         if_pc_reg    <= '0;
         if_instr_reg <= NOP_INSTR;
         if_valid_reg <= 1'b0;
      end else if (bus.pcSrc || bus.flush) begin
         if_instr_reg <= NOP_INSTR;
         if_valid_reg <= 1'b0;
      end else if (bus.en_IF) begin
         if (!empty) begin
            if_pc_reg    <= buf_pc[rd_ptr_reg];
            if_instr_reg <= buf_instr[rd_ptr_reg];
            if_valid_reg <= 1'b1;
         end else begin
            if_instr_reg <= NOP_INSTR;
            if_valid_reg <= 1'b0;
         end
      end
   end

   assign bus.if_pc    = if_pc_reg;
   assign bus.if_instr = if_instr_reg;
   assign bus.if_valid = if_valid_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a memory responder plus a program-order
// reference model (next expected pc restarts at branchPC on every redirect).
module tb_instr_fetch_unit;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] K   = 32'hA5A5_0000;

   logic clk = 1'b0;
   logic rst;
   instr_fetch_if bus();

   instr_fetch_unit #(.RESET_PC(32'h0), .BUF_DEPTH(2), .NOP_INSTR(NOP)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   int          gnt_mode;
   bit          rnd_delay;
   logic [31:0] slow_addr;
   int          slow_delay;
   bit          pend;
   int          pend_cnt;
   logic [31:0] pend_addr;
   bit          last_grant;
   logic [31:0] last_grant_addr;
   int          num_grants;
   int          proto_viol;
   bit          dlv;
   logic [31:0] dlv_pc, dlv_instr;
   int          cyc = 0;

   // One clock: capture grants at the edge, then at the falling edge note IF/ID updates
   // and drive the memory response and grant for the next cycle.
   task automatic tick();
      bit upd;
      @(posedge clk);
      upd = bus.en_IF || bus.flush || bus.pcSrc;
      last_grant = bus.imem_req && bus.imem_gnt;
      if (last_grant) begin
         if (pend) proto_viol++;
         pend = 1'b1;
         pend_addr = bus.imem_addr;
         last_grant_addr = bus.imem_addr;
         num_grants++;
         if (rnd_delay) pend_cnt = $urandom_range(1, 4);
         else if (bus.imem_addr == slow_addr) pend_cnt = slow_delay;
         else pend_cnt = 1;
      end
      @(negedge clk);
      cyc++;
      dlv = upd && bus.if_valid;
      dlv_pc = bus.if_pc;
      dlv_instr = bus.if_instr;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = $urandom;
      if (pend) begin
         if (pend_cnt <= 1) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata = pend_addr ^ K;
            pend = 1'b0;
         end else begin
            pend_cnt--;
         end
      end
      case (gnt_mode)
         0:       bus.imem_gnt = 1'b0;
         1:       bus.imem_gnt = 1'b1;
         default: bus.imem_gnt = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic set_defaults();
      bus.en_pc = 1'b1; bus.en_IF = 1'b1; bus.flush = 1'b0; bus.pcSrc = 1'b0;
      bus.branchPC = '0; bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
      gnt_mode = 1; rnd_delay = 1'b0; slow_addr = 32'h1; slow_delay = 1;
      pend = 1'b0; num_grants = 0; proto_viol = 0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      set_defaults();
      repeat (2) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bit found = 1'b0;
      rst = 1'b1;
      set_defaults();
      repeat (3) tick();
      tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
      tests++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.if_valid); end
      tests++; if (bus.if_instr !== NOP) begin fails++; $display("FAIL reset_instr: got %h expected %h", bus.if_instr, NOP); end
      tests++; if (bus.if_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h expected 0", bus.if_pc); end
      rst = 1'b0;
      #1;
      tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
         fails++; $display("FAIL reset_release_req: got req=%b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr); end
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (bus.if_valid && !bus.imem_req) found = 1'b1;
      end
      tests++; if (!found) begin fails++; $display("FAIL reset_reach_wait: got no valid instr with fetch outstanding within 20 cycles"); end
      #2;
      rst = 1'b1;
      pend = 1'b0;
      bus.imem_rvalid = 1'b0;
      #1;
      tests++; if ({bus.if_valid, bus.if_instr, bus.if_pc, bus.imem_req} !== {1'b0, NOP, 32'h0, 1'b0}) begin
         fails++; $display("FAIL reset_async: got valid=%b instr=%h pc=%h req=%b expected 0/%h/0/0",
                           bus.if_valid, bus.if_instr, bus.if_pc, bus.imem_req, NOP); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
         fails++; $display("FAIL reset_restart: got req=%b addr=%h expected req=1 addr=0", bus.imem_req, bus.imem_addr); end
   endtask

   task automatic test_straight();
      logic [31:0] exp_pc = 32'h0;
      int n = 0;
      int prev = 0;
      apply_reset();
      repeat (24) begin
         tick();
         if (dlv) begin
            tests++; if (dlv_pc !== exp_pc) begin fails++; $display("FAIL straight_pc: got %h expected %h", dlv_pc, exp_pc); end
            tests++; if (dlv_instr !== (exp_pc ^ K)) begin fails++; $display("FAIL straight_instr: got %h expected %h", dlv_instr, exp_pc ^ K); end
            if (n > 0) begin
               tests++; if (cyc - prev != 2) begin fails++; $display("FAIL straight_cadence: got %0d cycles expected 2", cyc - prev); end
            end
            prev = cyc;
            n++;
            exp_pc += 32'd4;
         end
      end
      tests++; if (n < 10) begin fails++; $display("FAIL straight_count: got %0d deliveries expected >=10", n); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_pc = 32'h0;
      int n = 0;
      apply_reset();
      bus.en_IF = 1'b0;
      repeat (10) tick();
      tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL bp_req_full: got %b expected 0", bus.imem_req); end
      tests++; if (num_grants != 2) begin fails++; $display("FAIL bp_grants: got %0d expected 2", num_grants); end
      bus.en_IF = 1'b1;
      repeat (16) begin
         tick();
         if (dlv) begin
            tests++; if (dlv_pc !== exp_pc || dlv_instr !== (exp_pc ^ K)) begin
               fails++; $display("FAIL bp_order: got pc=%h instr=%h expected pc=%h instr=%h", dlv_pc, dlv_instr, exp_pc, exp_pc ^ K); end
            exp_pc += 32'd4;
            n++;
         end
      end
      tests++; if (n < 6) begin fails++; $display("FAIL bp_count: got %0d deliveries expected >=6", n); end
   endtask

   task automatic test_redirect_wait();
      bit found = 1'b0;
      bit first = 1'b1;
      bit seen8 = 1'b0;
      logic [31:0] exp_pc = 32'h0;
      apply_reset();
      slow_addr = 32'h8;
      slow_delay = 4;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (dlv) begin
            tests++; if (dlv_pc !== exp_pc) begin fails++; $display("FAIL redir_pre_pc: got %h expected %h", dlv_pc, exp_pc); end
            exp_pc += 32'd4;
         end
         if (last_grant && last_grant_addr == 32'h8) found = 1'b1;
      end
      tests++; if (!found) begin fails++; $display("FAIL redir_setup: got no grant of 0x8 within 20 cycles"); end
      bus.pcSrc = 1'b1;
      bus.branchPC = 32'h100;
      tick();
      bus.pcSrc = 1'b0;
      tests++; if ({bus.if_valid, bus.if_instr} !== {1'b0, NOP}) begin
         fails++; $display("FAIL redir_bubble: got valid=%b instr=%h expected 0/%h", bus.if_valid, bus.if_instr, NOP); end
      tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL redir_discard_req: got %b expected 0", bus.imem_req); end
      repeat (30) begin
         tick();
         if (dlv) begin
            if (dlv_pc == 32'h8) seen8 = 1'b1;
            if (first) begin
               tests++; if (dlv_pc !== 32'h100 || dlv_instr !== (32'h100 ^ K)) begin
                  fails++; $display("FAIL redir_target: got pc=%h instr=%h expected pc=100 instr=%h", dlv_pc, dlv_instr, 32'h100 ^ K); end
               first = 1'b0;
            end
         end
      end
      tests++; if (first || seen8) begin fails++; $display("FAIL redir_stream: got target_seen=%b dropped_word_seen=%b expected 1/0", !first, seen8); end
      tests++; if (proto_viol != 0) begin fails++; $display("FAIL redir_protocol: got %0d overlapping grants expected 0", proto_viol); end
   endtask

   task automatic test_corner();
      bit got = 1'b0;
      bit first = 1'b1;
      int g = 0;
      int d = 0;
      logic [31:0] wexp [2];
      wexp[0] = 32'hFFFF_FFFC;
      wexp[1] = 32'h0;
      apply_reset();
      for (int i = 0; i < 5 && !got; i++) begin
         tick();
         got = last_grant;
      end
      tests++; if (!got || bus.imem_rvalid !== 1'b1) begin fails++; $display("FAIL corner_setup: got grant=%b rvalid=%b expected 1/1", got, bus.imem_rvalid); end
      bus.pcSrc = 1'b1;
      bus.branchPC = 32'h200;
      #1;
      tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL corner_req_redirect: got %b expected 0", bus.imem_req); end
      tick();
      bus.pcSrc = 1'b0;
      #1;
      tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h200}) begin
         fails++; $display("FAIL corner_rvalid_redirect: got req=%b addr=%h expected req=1 addr=200", bus.imem_req, bus.imem_addr); end
      for (int i = 0; i < 10 && first; i++) begin
         tick();
         if (dlv) begin
            tests++; if (dlv_pc !== 32'h200) begin fails++; $display("FAIL corner_first_after: got %h expected 200", dlv_pc); end
            first = 1'b0;
         end
      end
      gnt_mode = 0;
      repeat (3) tick();
      tests++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL corner_nognt_req: got %b expected 1", bus.imem_req); end
      bus.pcSrc = 1'b1;
      bus.branchPC = 32'h300;
      tick();
      bus.pcSrc = 1'b0;
      #1;
      tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h300}) begin
         fails++; $display("FAIL corner_nognt_redirect: got req=%b addr=%h expected req=1 addr=300", bus.imem_req, bus.imem_addr); end
      bus.pcSrc = 1'b1;
      bus.branchPC = 32'hFFFF_FFFC;
      tick();
      bus.pcSrc = 1'b0;
      gnt_mode = 1;
      repeat (14) begin
         tick();
         if (last_grant) begin
            if (g < 2) begin
               tests++; if (last_grant_addr !== wexp[g]) begin fails++; $display("FAIL corner_wrap_addr: got %h expected %h", last_grant_addr, wexp[g]); end
            end
            g++;
         end
         if (dlv) begin
            if (d < 2) begin
               tests++; if (dlv_pc !== wexp[d] || dlv_instr !== (wexp[d] ^ K)) begin
                  fails++; $display("FAIL corner_wrap_instr: got pc=%h instr=%h expected pc=%h instr=%h", dlv_pc, dlv_instr, wexp[d], wexp[d] ^ K); end
            end
            d++;
         end
      end
      tests++; if (g < 2 || d < 2) begin fails++; $display("FAIL corner_wrap_count: got grants=%0d deliveries=%0d expected >=2 each", g, d); end
   endtask

   task automatic test_flush();
      logic [31:0] exp_pc = 32'h4;
      int n = 0;
      apply_reset();
      bus.en_IF = 1'b0;
      repeat (10) tick();
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      tests++; if ({bus.if_valid, bus.if_instr} !== {1'b0, NOP}) begin
         fails++; $display("FAIL flush_bubble: got valid=%b instr=%h expected 0/%h", bus.if_valid, bus.if_instr, NOP); end
      tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) begin
         fails++; $display("FAIL flush_fetch_pc: got req=%b addr=%h expected req=1 addr=8", bus.imem_req, bus.imem_addr); end
      bus.en_IF = 1'b1;
      repeat (12) begin
         tick();
         if (dlv) begin
            tests++; if (dlv_pc !== exp_pc || dlv_instr !== (exp_pc ^ K)) begin
               fails++; $display("FAIL flush_order: got pc=%h instr=%h expected pc=%h instr=%h", dlv_pc, dlv_instr, exp_pc, exp_pc ^ K); end
            exp_pc += 32'd4;
            n++;
         end
      end
      tests++; if (n < 4) begin fails++; $display("FAIL flush_count: got %0d deliveries expected >=4", n); end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc = 32'h0;
      logic [31:0] pv_pc, pv_instr;
      logic        pv_valid;
      bit br;
      int n = 0;
      apply_reset();
      gnt_mode = 2;
      rnd_delay = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bus.en_pc = ($urandom_range(0, 9) < 8);
         bus.en_IF = ($urandom_range(0, 9) < 7);
         br = ($urandom_range(0, 19) == 0);
         bus.pcSrc = br;
         if (br) bus.branchPC = 32'($urandom_range(0, 4095)) << 2;
         pv_pc = bus.if_pc;
         pv_instr = bus.if_instr;
         pv_valid = bus.if_valid;
         #1;
         if (!bus.en_pc || br) begin
            tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL rand_req_gate: got %b expected 0", bus.imem_req); end
         end
         tick();
         if (br) begin
            tests++; if ({bus.if_valid, bus.if_instr} !== {1'b0, NOP}) begin
               fails++; $display("FAIL rand_redirect_bubble: got valid=%b instr=%h expected 0/%h", bus.if_valid, bus.if_instr, NOP); end
            exp_pc = bus.branchPC;
         end else if (dlv) begin
            tests++; if (dlv_pc !== exp_pc || dlv_instr !== (exp_pc ^ K)) begin
               fails++; $display("FAIL rand_order: got pc=%h instr=%h expected pc=%h instr=%h", dlv_pc, dlv_instr, exp_pc, exp_pc ^ K); end
            exp_pc += 32'd4;
            n++;
         end else if (!bus.en_IF) begin
            tests++; if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {pv_valid, pv_pc, pv_instr}) begin
               fails++; $display("FAIL rand_hold: got %b/%h/%h expected %b/%h/%h", bus.if_valid, bus.if_pc, bus.if_instr, pv_valid, pv_pc, pv_instr); end
         end
      end
      bus.pcSrc = 1'b0;
      tests++; if (proto_viol != 0) begin fails++; $display("FAIL rand_protocol: got %0d overlapping grants expected 0", proto_viol); end
      tests++; if (n < 20) begin fails++; $display("FAIL rand_count: got %0d deliveries expected >=20", n); end
   endtask

   initial begin
      rst = 1'b1;
      set_defaults();
      test_reset();
      test_straight();
      test_backpressure();
      test_redirect_wait();
      test_corner();
      test_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
